// File: rtl/als_read_scheduler.sv
// PmodALS (ADC081S021) read sequencer: periodic/on-demand SPI reads, 8-bit light value
// extraction and block averaging of 2**AVG_LOG2 samples.
module als_read_scheduler #(
  parameter int CLK_DIV  = 4,
  parameter int PERIOD   = 2000,
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  output logic       busy,
  output logic       cs,
  output logic       sck,
  input  logic       sdo,
  output logic [7:0] value,
  output logic       valid,
  output logic [7:0] value_avg,
  output logic       avg_valid
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW = 8 + AVG_LOG2;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [4:0]    AVG_LAST = 5'((1 << AVG_LOG2) - 1);

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic [4:0]    half_cnt;
  logic [PW-1:0] period_cnt;
  logic          enable_q, pending;
  logic [7:0]    shreg;
  logic [AW-1:0] acc, sum;
  logic [4:0]    sample_cnt;
  logic [7:0]    avg_next;
  logic [3:0]    bit_idx;
  logic          div_last, tick, trigger, go, sample, frame_done;

  assign div_last   = (div_cnt == DIV_LAST);
  assign tick       = enable && (period_cnt == PER_LAST);
  assign trigger    = tick | start;
  assign go         = (state == IDLE) && (trigger || pending);
  assign bit_idx    = half_cnt[4:1];
  // Only frame bits 3..10 (the data byte) are kept; at the end of a frame shreg holds them MSB first.
  assign sample     = (state == SHIFT) && div_last && !half_cnt[0] && (bit_idx >= 4'd3) && (bit_idx <= 4'd10);
  assign frame_done = (state == SHIFT) && div_last && (half_cnt == 5'd31);
  assign sum        = acc + AW'(shreg);
  assign avg_next   = 8'(sum >> AVG_LOG2);

  assign busy = (state != IDLE);
  assign cs   = !((state == SETUP) || (state == SHIFT));
  assign sck  = !((state == SHIFT) && !half_cnt[0]);

  // NOTE: every register below uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (go) state_next = SETUP;
      SETUP: if (div_last) state_next = SHIFT;
      SHIFT: if (frame_done) state_next = HOLD;
      HOLD:  if (div_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      div_cnt  <= (state == IDLE || div_last) ? '0 : div_cnt + 1'b1;
      if (state != SHIFT) half_cnt <= '0;
      else if (div_last)  half_cnt <= half_cnt + 1'b1;
    end
  end

  // Disabling clears the period counter and drops any queued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      enable_q   <= 1'b0;
      pending    <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable || period_cnt == PER_LAST) period_cnt <= '0;
      else                                    period_cnt <= period_cnt + 1'b1;
      if (enable_q && !enable)         pending <= 1'b0;
      else if (go)                     pending <= 1'b0;
      else if (trigger && state != IDLE) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      value      <= '0;
      valid      <= 1'b0;
      value_avg  <= '0;
      avg_valid  <= 1'b0;
      acc        <= '0;
      sample_cnt <= '0;
    end else begin
      valid     <= 1'b0;
      avg_valid <= 1'b0;
      if (sample) shreg <= {shreg[6:0], sdo};
      if (frame_done) begin
        value <= shreg;
        valid <= 1'b1;
        if (sample_cnt == AVG_LAST) begin
          value_avg  <= avg_next;
          avg_valid  <= 1'b1;
          acc        <= '0;
          sample_cnt <= '0;
        end else begin
          acc        <= sum;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_als_read_scheduler.sv
// Directed bench for als_read_scheduler with an ADC081S021-style sensor stub
// (CLK_DIV=4, PERIOD=2000, AVG_LOG2=2).
module tb_als_read_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, enable, start, sdo;
  logic       busy, cs, sck, valid, avg_valid;
  logic [7:0] value, value_avg;

  als_read_scheduler #(.CLK_DIV(4), .PERIOD(2000), .AVG_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .busy(busy),
    .cs(cs), .sck(sck), .sdo(sdo), .value(value), .valid(valid),
    .value_avg(value_avg), .avg_valid(avg_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Sensor stub: first bit appears on cs fall, later bits on sck falling edges.
  logic [15:0] frame = 16'h0;
  int   rises = 0;
  logic cs_q  = 1'b1;
  logic sck_q = 1'b1;
  always @(cs or sck) begin
    if (!cs && cs_q) rises = 0;
    else if (!cs && sck && !sck_q) rises = rises + 1;
    if (!cs && (!sck || rises == 0)) sdo = (rises < 16) ? frame[15 - rises] : 1'b0;
    cs_q  = cs;
    sck_q = sck;
  end

  // Free-running activity counters, sampled on the falling clock edge.
  int cyc = 0, busy_total = 0, cs_low_total = 0, valid_total = 0, avg_total = 0;
  int avg_stray = 0, busy_rises = 0, last_rise = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_total++;
    if (!cs) cs_low_total++;
    if (valid) valid_total++;
    if (avg_valid) avg_total++;
    if (avg_valid && !valid) avg_stray++;
    if (busy && !busy_q) begin
      busy_rises++;
      last_rise = cyc;
    end
    busy_q = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      step();
      n++;
    end
    check(name, busy, lvl);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_read(input logic [7:0] data);
    frame = {3'b000, data, 4'b0000, 1'b0};
    pulse_start();
    wait_busy(1'b1, 5, "read_start");
    wait_busy(1'b0, 200, "read_end");
  endtask

  typedef struct {
    logic [7:0] data;
    int         exp_avg_pulses;
    logic [7:0] exp_avg;
  } vec_t;

  initial begin
    vec_t vecs[12];
    int v0, a0, b0, bt0, cl0, n, prev;
    logic [7:0] series[4];

    vecs[0]  = '{8'h00, 0, 8'h00};
    vecs[1]  = '{8'hFF, 0, 8'h00};
    vecs[2]  = '{8'h80, 0, 8'h00};
    vecs[3]  = '{8'h01, 1, 8'h60};
    vecs[4]  = '{8'hA5, 0, 8'h60};
    vecs[5]  = '{8'h5A, 0, 8'h60};
    vecs[6]  = '{8'h3C, 0, 8'h60};
    vecs[7]  = '{8'hC3, 1, 8'h7F};
    vecs[8]  = '{8'hFF, 0, 8'h7F};
    vecs[9]  = '{8'hFF, 0, 8'h7F};
    vecs[10] = '{8'hFF, 0, 8'h7F};
    vecs[11] = '{8'hFF, 1, 8'hFF};

    // Reset state
    sdo = 1'b0;
    do_reset();
    check("rst_cs", cs, 1'b1);
    check("rst_sck", sck, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_value", value, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_value_avg", value_avg, 8'h00);
    check("rst_avg_valid", avg_valid, 1'b0);

    // Single on-demand read of 0xA5: framing and timing
    v0 = valid_total; bt0 = busy_total; cl0 = cs_low_total;
    do_read(8'hA5);
    check("t1_value", value, 8'hA5);
    check("t1_valid_cycles", valid_total - v0, 1);
    check("t1_sck_rises", rises, 16);
    check("t1_busy_cycles", busy_total - bt0, 136);
    check("t1_cs_low_cycles", cs_low_total - cl0, 132);
    check("t1_cs_idle", cs, 1'b1);

    // Table of start-triggered reads, averaged in blocks of four
    do_reset();
    for (int i = 0; i < 12; i++) begin
      v0 = valid_total; a0 = avg_total;
      do_read(vecs[i].data);
      check($sformatf("vec%0d_value", i), value, vecs[i].data);
      check($sformatf("vec%0d_valid", i), valid_total - v0, 1);
      check($sformatf("vec%0d_avg_pulse", i), avg_total - a0, vecs[i].exp_avg_pulses);
      check($sformatf("vec%0d_value_avg", i), value_avg, vecs[i].exp_avg);
    end

    // Two starts during a busy read: one back-to-back extra read
    do_reset();
    b0 = busy_rises; v0 = valid_total;
    frame = {3'b000, 8'h55, 5'b00000};
    pulse_start();
    wait_busy(1'b1, 5, "t3_start");
    repeat (20) step();
    pulse_start();
    repeat (10) step();
    pulse_start();
    wait_busy(1'b0, 200, "t3_first_end");
    n = 0;
    while (!busy && n < 50) begin
      step();
      n++;
    end
    check("t3_gap_cycles", n, 1);
    wait_busy(1'b0, 200, "t3_second_end");
    repeat (300) step();
    check("t3_reads", busy_rises - b0, 2);
    check("t3_valids", valid_total - v0, 2);
    check("t3_value", value, 8'h55);

    // start coincident with the period tick: single read, nothing queued
    do_reset();
    b0 = busy_rises;
    frame = {3'b000, 8'h33, 5'b00000};
    enable = 1'b1;
    repeat (1999) step();
    pulse_start();
    wait_busy(1'b1, 5, "t4_start");
    wait_busy(1'b0, 200, "t4_end");
    repeat (200) step();
    check("t4_reads", busy_rises - b0, 1);
    check("t4_sck_rises", rises, 16);
    check("t4_value", value, 8'h33);
    enable = 1'b0;

    // Periodic reads every 2000 cycles, averaged
    do_reset();
    series = '{8'h10, 8'h20, 8'h30, 8'h41};
    a0 = avg_total; prev = 0;
    frame = {3'b000, series[0], 5'b00000};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame = {3'b000, series[i], 5'b00000};
      wait_busy(1'b1, 2100, $sformatf("t2_read%0d_start", i));
      if (i > 0) check($sformatf("t2_interval%0d", i), last_rise - prev, 2000);
      prev = last_rise;
      wait_busy(1'b0, 200, $sformatf("t2_read%0d_end", i));
      check($sformatf("t2_value%0d", i), value, series[i]);
    end
    check("t2_avg_pulses", avg_total - a0, 1);
    check("t2_value_avg", value_avg, 8'h28);
    enable = 1'b0;

    // Disable mid-read with a queued read: only the current read completes
    do_reset();
    frame = {3'b000, 8'h77, 5'b00000};
    enable = 1'b1;
    wait_busy(1'b1, 2100, "t6_start");
    b0 = busy_rises - 1; v0 = valid_total;
    repeat (10) step();
    pulse_start();
    repeat (10) step();
    enable = 1'b0;
    wait_busy(1'b0, 200, "t6_end");
    repeat (2500) step();
    check("t6_reads", busy_rises - b0, 1);
    check("t6_valids", valid_total - v0, 1);
    check("t6_value", value, 8'h77);

    // Reset in the middle of a frame, then a clean read
    do_reset();
    v0 = valid_total;
    frame = {3'b000, 8'h99, 5'b00000};
    pulse_start();
    n = 0;
    while (rises < 7 && n < 200) begin
      step();
      n++;
    end
    check("t5_rise7", rises, 7);
    rst_n = 1'b0;
    #1;
    check("t5_cs", cs, 1'b1);
    check("t5_sck", sck, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_value", value, 8'h00);
    repeat (3) step();
    check("t5_no_valid", valid_total - v0, 0);
    rst_n = 1'b1;
    step();
    do_read(8'h3C);
    check("t5_clean_value", value, 8'h3C);
    check("t5_clean_rises", rises, 16);

    check("avg_valid_aligned", avg_stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
